// File: rtl/hazard_ctrl_if.sv
// Pipeline-side signal bundle for hazard_ctrl: stage register fields in, stall/flush/forward controls out.
// HAZARD_PERF_EN adds the 32-bit stall_cnt performance counter output.
interface hazard_ctrl_if #(
  parameter int REG_AW = 5
);
  logic [REG_AW-1:0] rs1_id;
  logic [REG_AW-1:0] rs2_id;
  logic              use_rs1_id;
  logic              use_rs2_id;
  logic [REG_AW-1:0] rs1_ex;
  logic [REG_AW-1:0] rs2_ex;
  logic [REG_AW-1:0] rd_ex;
  logic [REG_AW-1:0] rd_mem;
  logic [REG_AW-1:0] rd_wb;
  logic              regw_ex;
  logic              regw_mem;
  logic              regw_wb;
  logic [1:0]        mem2reg_ex;
  logic              branch_taken_ex;
  logic              mem_req_mem;
  logic              dmem_ready;

  logic              stall_if;
  logic              stall_id;
  logic              stall_ex;
  logic              stall_mem;
  logic              flush_id;
  logic              flush_ex;
  logic              flush_wb;
  logic [1:0]        fwd_a;
  logic [1:0]        fwd_b;
  logic              mem_timeout;
`ifdef HAZARD_PERF_EN
  logic [31:0]       stall_cnt;
`endif

  // Pipeline datapath side: drives stage fields, consumes controls.
  modport master (
`ifdef HAZARD_PERF_EN
    input  stall_cnt,
`endif
    output rs1_id, rs2_id, use_rs1_id, use_rs2_id, rs1_ex, rs2_ex,
    output rd_ex, rd_mem, rd_wb, regw_ex, regw_mem, regw_wb, mem2reg_ex,
    output branch_taken_ex, mem_req_mem, dmem_ready,
    input  stall_if, stall_id, stall_ex, stall_mem, flush_id, flush_ex, flush_wb,
    input  fwd_a, fwd_b, mem_timeout
  );

  // Hazard controller side.
  modport slave (
`ifdef HAZARD_PERF_EN
    output stall_cnt,
`endif
    input  rs1_id, rs2_id, use_rs1_id, use_rs2_id, rs1_ex, rs2_ex,
    input  rd_ex, rd_mem, rd_wb, regw_ex, regw_mem, regw_wb, mem2reg_ex,
    input  branch_taken_ex, mem_req_mem, dmem_ready,
    output stall_if, stall_id, stall_ex, stall_mem, flush_id, flush_ex, flush_wb,
    output fwd_a, fwd_b, mem_timeout
  );
endinterface

// File: rtl/hazard_ctrl.sv
// 5-stage pipeline hazard controller: load-use stall, branch flush, EX forwarding, dmem wait/timeout.
// Optional feature macro: HAZARD_PERF_EN (adds stall_cnt, counting cycles with stall_if asserted).
module hazard_ctrl #(
  parameter int REG_AW   = 5,
  parameter int MAX_WAIT = 16
) (
  input  logic          clk,
  input  logic          rst,
  hazard_ctrl_if.slave  hz
);

  typedef enum logic [1:0] {ST_RUN = 2'd0, ST_WAIT = 2'd1, ST_ERR = 2'd2} state_t;

  localparam logic [REG_AW-1:0] REG_ZERO   = '0;
  localparam logic [7:0]        MAX_WAIT_C = 8'(MAX_WAIT);

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;

  logic load_use;
  logic mem_busy;
  logic stall_all;
  logic eval_pipe;
  logic timeout;

  assign load_use = hz.regw_ex && (hz.mem2reg_ex == 2'b01) && (hz.rd_ex != REG_ZERO) &&
                    ((hz.use_rs1_id && (hz.rs1_id == hz.rd_ex)) ||
                     (hz.use_rs2_id && (hz.rs2_id == hz.rd_ex)));
  assign mem_busy = hz.mem_req_mem && !hz.dmem_ready;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_RUN;
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // eval_pipe marks cycles where branch/load-use arbitration applies (no memory stall active).
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    stall_all = 1'b0;
    eval_pipe = 1'b0;
    timeout   = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (mem_busy) begin
          stall_all = 1'b1;
          state_d   = ST_WAIT;
          cnt_d     = 8'd1;
        end else begin
          eval_pipe = 1'b1;
        end
      end
      ST_WAIT: begin
        if (mem_busy) begin
          stall_all = 1'b1;
          if (cnt_q == MAX_WAIT_C) begin
            state_d = ST_ERR;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end else begin
          eval_pipe = 1'b1;
          state_d   = ST_RUN;
          cnt_d     = 8'd0;
        end
      end
      ST_ERR: begin
        stall_all = 1'b1;
        timeout   = 1'b1;
      end
      default: begin
        state_d = ST_RUN;
        cnt_d   = 8'd0;
      end
    endcase
  end

  logic branch_flush;
  logic lu_stall;

  // A taken branch squashes the consumer, so it suppresses the load-use stall.
  assign branch_flush = eval_pipe && hz.branch_taken_ex;
  assign lu_stall     = eval_pipe && !hz.branch_taken_ex && load_use;

  assign hz.stall_if    = rst && (stall_all || lu_stall);
  assign hz.stall_id    = rst && (stall_all || lu_stall);
  assign hz.stall_ex    = rst && stall_all;
  assign hz.stall_mem   = rst && stall_all;
  assign hz.flush_id    = rst && branch_flush;
  assign hz.flush_ex    = rst && (branch_flush || lu_stall);
  assign hz.flush_wb    = rst && stall_all;
  assign hz.mem_timeout = rst && timeout;

  assign hz.fwd_a = (hz.regw_mem && (hz.rd_mem != REG_ZERO) && (hz.rd_mem == hz.rs1_ex)) ? 2'b01 :
                    (hz.regw_wb  && (hz.rd_wb  != REG_ZERO) && (hz.rd_wb  == hz.rs1_ex)) ? 2'b10 :
                                                                                          2'b00;
  assign hz.fwd_b = (hz.regw_mem && (hz.rd_mem != REG_ZERO) && (hz.rd_mem == hz.rs2_ex)) ? 2'b01 :
                    (hz.regw_wb  && (hz.rd_wb  != REG_ZERO) && (hz.rd_wb  == hz.rs2_ex)) ? 2'b10 :
                                                                                          2'b00;

`ifdef HAZARD_PERF_EN
  logic [31:0] stall_cnt_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      stall_cnt_q <= 32'd0;
    end else if (hz.stall_if) begin
      stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign hz.stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed self-checking bench for hazard_ctrl (MAX_WAIT=4); perf counter checked when HAZARD_PERF_EN is defined.
module tb_hazard_ctrl;
  logic clk;
  logic rst;
  int   checks;
  int   errors;

  hazard_ctrl_if #(.REG_AW(5)) hz ();

  hazard_ctrl #(.REG_AW(5), .MAX_WAIT(4)) dut (
    .clk (clk),
    .rst (rst),
    .hz  (hz.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Control vector order: stall_if, stall_id, stall_ex, stall_mem, flush_id, flush_ex, flush_wb.
  function automatic logic [6:0] ctl_vec();
    return {hz.stall_if, hz.stall_id, hz.stall_ex, hz.stall_mem,
            hz.flush_id, hz.flush_ex, hz.flush_wb};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after posedge; outputs are checked 2 units later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic idle();
    hz.rs1_id = '0; hz.rs2_id = '0; hz.use_rs1_id = 1'b0; hz.use_rs2_id = 1'b0;
    hz.rs1_ex = '0; hz.rs2_ex = '0;
    hz.rd_ex = '0; hz.rd_mem = '0; hz.rd_wb = '0;
    hz.regw_ex = 1'b0; hz.regw_mem = 1'b0; hz.regw_wb = 1'b0;
    hz.mem2reg_ex = 2'b00; hz.branch_taken_ex = 1'b0;
    hz.mem_req_mem = 1'b0; hz.dmem_ready = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;

    // Reset with a busy memory and a forwarding match: controls forced low, forwarding live.
    rst = 1'b0;
    idle();
    hz.mem_req_mem = 1'b1;
    hz.regw_mem = 1'b1; hz.rd_mem = 5'd7; hz.rs1_ex = 5'd7;
    tick(); settle();
    check("rst_ctl", 32'(ctl_vec()), 32'h00);
    check("rst_timeout", 32'(hz.mem_timeout), 32'd0);
    check("rst_fwd_a", 32'(hz.fwd_a), 32'd1);
    check("rst_state", 32'(dut.state_q), 32'd0);
    check("rst_cnt", 32'(dut.cnt_q), 32'd0);

    rst = 1'b1;
    idle();
    tick(); settle();
    check("idle_ctl", 32'(ctl_vec()), 32'h00);
    check("idle_fwd", 32'({hz.fwd_a, hz.fwd_b}), 32'h0);

    // Load x5 in EX, ID reads rs1=5: one bubble.
    hz.regw_ex = 1'b1; hz.mem2reg_ex = 2'b01; hz.rd_ex = 5'd5;
    hz.use_rs1_id = 1'b1; hz.rs1_id = 5'd5;
    settle();
    check("lu_rs1", 32'(ctl_vec()), 32'(7'b1100010));
    tick();
    hz.regw_ex = 1'b0; hz.mem2reg_ex = 2'b00; hz.rd_ex = 5'd0;
    hz.regw_mem = 1'b1; hz.rd_mem = 5'd5;
    settle();
    check("lu_clear", 32'(ctl_vec()), 32'h00);

    // Reserved writeback select, rd=0 and use flag low must not stall.
    idle();
    hz.regw_ex = 1'b1; hz.mem2reg_ex = 2'b11; hz.rd_ex = 5'd5;
    hz.use_rs1_id = 1'b1; hz.rs1_id = 5'd5;
    settle();
    check("lu_m2r11", 32'(ctl_vec()), 32'h00);
    hz.mem2reg_ex = 2'b01; hz.rd_ex = 5'd0; hz.rs1_id = 5'd0;
    settle();
    check("lu_rd0", 32'(ctl_vec()), 32'h00);
    hz.rd_ex = 5'd9; hz.rs1_id = 5'd9; hz.use_rs1_id = 1'b0;
    settle();
    check("lu_nouse", 32'(ctl_vec()), 32'h00);
    hz.use_rs2_id = 1'b1; hz.rs2_id = 5'd9; hz.rs1_id = 5'd2;
    settle();
    check("lu_rs2", 32'(ctl_vec()), 32'(7'b1100010));

    // Branch with load-use in the same cycle: flush wins, no stall.
    hz.branch_taken_ex = 1'b1;
    settle();
    check("br_lu", 32'(ctl_vec()), 32'(7'b0000110));
    tick();

    // Forwarding priority and register 0.
    idle();
    hz.regw_mem = 1'b1; hz.rd_mem = 5'd3; hz.regw_wb = 1'b1; hz.rd_wb = 5'd3;
    hz.rs1_ex = 5'd3;
    settle();
    check("fwd_mem_prio", 32'(hz.fwd_a), 32'd1);
    hz.rd_mem = 5'd0; hz.rs2_ex = 5'd0;
    settle();
    check("fwd_b_r0", 32'(hz.fwd_b), 32'd0);
    check("fwd_a_wb", 32'(hz.fwd_a), 32'd2);
    hz.rd_mem = 5'd3; hz.regw_mem = 1'b0; hz.rs2_ex = 5'd3;
    settle();
    check("fwd_b_wb", 32'(hz.fwd_b), 32'd2);
    hz.regw_wb = 1'b0;
    settle();
    check("fwd_none", 32'({hz.fwd_a, hz.fwd_b}), 32'h0);
    tick();

    // Three-cycle memory wait, then ready.
    idle();
    hz.mem_req_mem = 1'b1;
    for (int i = 0; i < 3; i++) begin
      settle();
      check($sformatf("wait_c%0d", i), 32'(ctl_vec()), 32'(7'b1111001));
      tick();
    end
    hz.dmem_ready = 1'b1;
    settle();
    check("wait_ready", 32'(ctl_vec()), 32'h00);
    tick();
    hz.mem_req_mem = 1'b0; hz.dmem_ready = 1'b0;
    settle();
    check("wait_state", 32'(dut.state_q), 32'd0);
    check("wait_cnt", 32'(dut.cnt_q), 32'd0);

    // One busy cycle, then ready together with a taken branch.
    hz.mem_req_mem = 1'b1;
    tick();
    hz.dmem_ready = 1'b1; hz.branch_taken_ex = 1'b1;
    settle();
    check("wait_br", 32'(ctl_vec()), 32'(7'b0000110));
    tick();

    // Timeout: busy in RUN plus WAIT counts 1..4, then ERR.
    idle();
    hz.mem_req_mem = 1'b1;
    for (int i = 0; i < 5; i++) begin
      settle();
      check($sformatf("to_pre%0d", i), 32'(hz.mem_timeout), 32'd0);
      tick();
    end
    settle();
    check("to_fire", 32'(hz.mem_timeout), 32'd1);
    check("to_ctl", 32'(ctl_vec()), 32'(7'b1111001));
    hz.mem_req_mem = 1'b0;
    tick(); tick(); settle();
    check("to_sticky", 32'(hz.mem_timeout), 32'd1);
    check("to_sticky_ctl", 32'(ctl_vec()), 32'(7'b1111001));
    rst = 1'b0;
    settle();
    check("to_rst_flag", 32'(hz.mem_timeout), 32'd0);
    check("to_rst_ctl", 32'(ctl_vec()), 32'h00);
    tick();
    rst = 1'b1;
    settle();
    check("to_rst_state", 32'(dut.state_q), 32'd0);
    check("to_rst_timeout", 32'(hz.mem_timeout), 32'd0);

`ifdef HAZARD_PERF_EN
    // One load-use bubble plus a 3-cycle wait.
    idle();
    hz.regw_ex = 1'b1; hz.mem2reg_ex = 2'b01; hz.rd_ex = 5'd5;
    hz.use_rs1_id = 1'b1; hz.rs1_id = 5'd5;
    tick();
    idle();
    hz.mem_req_mem = 1'b1;
    tick(); tick(); tick();
    hz.dmem_ready = 1'b1;
    tick();
    idle();
    settle();
    check("perf_cnt", hz.stall_cnt, 32'd4);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
